// File: rtl/sockit_spi_pkg.sv
// Shared helpers for the SPI master FIFOs.
// Pointer wrap, level width and gray-code conversion.
package sockit_spi_pkg;

  function automatic int unsigned ptr_inc(
    input int unsigned ptr,
    input int unsigned dep
  );
    return (ptr == dep - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned lvl_width(
    input int unsigned dep,
    input int unsigned oreg
  );
    return $clog2(dep + oreg + 1);
  endfunction

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sockit_spi_fifo_oreg.sv
// Single-entry valid/ready output register.
// Load wins over pop; clear wins over both.
module sockit_spi_fifo_oreg #(
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_ld,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);

  logic          r_vld;
  logic [DW-1:0] r_dat;

  // occupancy flag of the single entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_vld <= 1'b0;
    else if (i_clr) r_vld <= 1'b0;
    else if (i_ld)  r_vld <= 1'b1;
    else if (i_pop) r_vld <= 1'b0;
  end

  // capture the head word from memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_dat <= '0;
    else if (i_ld && !i_clr) r_dat <= i_dat;
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/sockit_spi_fifo.sv
// Single-clock handshake FIFO, any depth.
// Level flags registered; optional output stage.
module sockit_spi_fifo
  import sockit_spi_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int DEP  = 4,
  parameter  int OREG = 0,
  parameter  int AFL  = DEP - 1,
  parameter  int AEM  = 1,
  localparam int LW   = lvl_width(DEP, OREG)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cdi_vld,
  output logic          cdi_rdy,
  input  logic [DW-1:0] cdi_dat,
  output logic          cdo_vld,
  input  logic          cdo_rdy,
  output logic [DW-1:0] cdo_dat,
  output logic [LW-1:0] lvl,
  output logic          afl,
  output logic          aem
);

  localparam int PW = $clog2(DEP);
  localparam int CW = $clog2(DEP + 1);

  logic [DW-1:0] r_mem [DEP];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_mcnt;
  logic [LW-1:0] r_lvl;
  logic          r_afl;
  logic          r_aem;

  logic          w_push;
  logic          w_pop;
  logic          w_mrd;
  logic [CW-1:0] w_mcnt_n;
  logic [LW-1:0] w_lvl_n;

  assign cdi_rdy = (r_mcnt != CW'(DEP));
  assign w_push  = cdi_vld & cdi_rdy;
  assign w_pop   = cdo_vld & cdo_rdy;

  if (OREG != 0) begin : g_oreg
    assign w_mrd = (!cdo_vld || w_pop)
                && (r_mcnt != '0);
    sockit_spi_fifo_oreg #(
      .DW (DW)
    ) u_oreg (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr),
      .i_ld  (w_mrd),
      .i_dat (r_mem[r_rp]),
      .i_pop (w_pop),
      .o_vld (cdo_vld),
      .o_dat (cdo_dat)
    );
  end else begin : g_direct
    assign cdo_vld = (r_mcnt != '0);
    assign cdo_dat = r_mem[r_rp];
    assign w_mrd   = w_pop;
  end

  // memory occupancy after this edge
  always_comb begin
    w_mcnt_n = r_mcnt;
    unique case ({w_push, w_mrd})
      2'b10:   w_mcnt_n = r_mcnt + CW'(1);
      2'b01:   w_mcnt_n = r_mcnt - CW'(1);
      default: ;
    endcase
    if (clr) w_mcnt_n = '0;
  end

  // total held words after this edge
  always_comb begin
    w_lvl_n = r_lvl;
    unique case ({w_push, w_pop})
      2'b10:   w_lvl_n = r_lvl + LW'(1);
      2'b01:   w_lvl_n = r_lvl - LW'(1);
      default: ;
    endcase
    if (clr) w_lvl_n = '0;
  end

  // pointers wrap explicitly at DEP-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (clr) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push)
        r_wp <= PW'(ptr_inc(32'(r_wp), DEP));
      if (w_mrd)
        r_rp <= PW'(ptr_inc(32'(r_rp), DEP));
    end
  end

  // occupancy, level and threshold flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcnt <= '0;
      r_lvl  <= '0;
      r_afl  <= (AFL <= 0);
      r_aem  <= 1'b1;
    end else begin
      r_mcnt <= w_mcnt_n;
      r_lvl  <= w_lvl_n;
      r_afl  <= (int'(w_lvl_n) >= AFL);
      r_aem  <= (int'(w_lvl_n) <= AEM);
    end
  end

  // storage, not reset
  always_ff @(posedge clk) begin
    if (w_push && !clr)
      r_mem[r_wp] <= cdi_dat;
  end

  assign lvl = r_lvl;
  assign afl = r_afl;
  assign aem = r_aem;

endmodule

// File: tb/tb_sockit_spi_fifo.sv
// Directed bench: DEP=5 direct read and
// DEP=4 registered-output instances.
module tb_sockit_spi_fifo;

  logic clk;
  logic rst;

  logic       a_clr, a_vld, a_rdy;
  logic [7:0] a_dat;
  logic       a_cdi_rdy, a_cdo_vld;
  logic [7:0] a_cdo_dat;
  logic [2:0] a_lvl;
  logic       a_afl, a_aem;

  logic       b_clr, b_vld, b_rdy;
  logic [7:0] b_dat;
  logic       b_cdi_rdy, b_cdo_vld;
  logic [7:0] b_cdo_dat;
  logic [2:0] b_lvl;
  logic       b_afl, b_aem;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq[$];

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_dat;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t tv[$];

  sockit_spi_fifo #(
    .DW (8), .DEP (5), .OREG (0)
  ) u_a (
    .clk     (clk),
    .rst     (rst),
    .clr     (a_clr),
    .cdi_vld (a_vld),
    .cdi_rdy (a_cdi_rdy),
    .cdi_dat (a_dat),
    .cdo_vld (a_cdo_vld),
    .cdo_rdy (a_rdy),
    .cdo_dat (a_cdo_dat),
    .lvl     (a_lvl),
    .afl     (a_afl),
    .aem     (a_aem)
  );

  sockit_spi_fifo #(
    .DW (8), .DEP (4), .OREG (1)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .clr     (b_clr),
    .cdi_vld (b_vld),
    .cdi_rdy (b_cdi_rdy),
    .cdi_dat (b_dat),
    .cdo_vld (b_cdo_vld),
    .cdo_rdy (b_rdy),
    .cdo_dat (b_cdo_dat),
    .lvl     (b_lvl),
    .afl     (b_afl),
    .aem     (b_aem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic add(
    input logic       c,
    input logic       v,
    input logic [7:0] d,
    input logic       r,
    input logic       ir,
    input logic       ov,
    input logic [7:0] ed,
    input logic [2:0] el
  );
    vec_t t;
    t.clr = c; t.vld = v; t.dat = d; t.rdy = r;
    t.e_ir = ir; t.e_ov = ov;
    t.e_dat = ed; t.e_lvl = el;
    tv.push_back(t);
  endtask

  // one cycle on A, checked against a queue model
  task automatic cyc_a(
    input logic       v,
    input logic [7:0] d,
    input logic       r,
    input string      nm
  );
    int n;
    @(posedge clk); #1;
    a_clr = 1'b0; a_vld = v; a_dat = d; a_rdy = r;
    @(negedge clk);
    n = mq.size();
    chk({nm, "_ir"}, 32'(a_cdi_rdy), 32'(n < 5));
    chk({nm, "_ov"}, 32'(a_cdo_vld), 32'(n > 0));
    if (n > 0)
      chk({nm, "_dat"}, 32'(a_cdo_dat), 32'(mq[0]));
    chk({nm, "_lvl"}, 32'(a_lvl), n);
    chk({nm, "_afl"}, 32'(a_afl), 32'(n >= 4));
    chk({nm, "_aem"}, 32'(a_aem), 32'(n <= 1));
    if (r && n > 0) void'(mq.pop_front());
    if (v && n < 5) mq.push_back(d);
  endtask

  task automatic cyc_b(
    input logic       v,
    input logic [7:0] d,
    input logic       r
  );
    @(posedge clk); #1;
    b_clr = 1'b0; b_vld = v; b_dat = d; b_rdy = r;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] nxt;
    logic [7:0] bexp [5];
    bexp[0] = 8'h5A; bexp[1] = 8'h61;
    bexp[2] = 8'h62; bexp[3] = 8'h63;
    bexp[4] = 8'h64;

    rst = 1'b0;
    a_clr = 0; a_vld = 0; a_dat = 0; a_rdy = 0;
    b_clr = 0; b_vld = 0; b_dat = 0; b_rdy = 0;

    // test 1: fill to full, refuse, drain
    add(0,1,8'h11,0, 1,0,8'h00,0);
    add(0,1,8'h12,0, 1,1,8'h11,1);
    add(0,1,8'h13,0, 1,1,8'h11,2);
    add(0,1,8'h14,0, 1,1,8'h11,3);
    add(0,1,8'h15,0, 1,1,8'h11,4);
    add(0,1,8'h16,0, 0,1,8'h11,5);
    add(0,0,8'h00,1, 0,1,8'h11,5);
    add(0,0,8'h00,1, 1,1,8'h12,4);
    add(0,0,8'h00,1, 1,1,8'h13,3);
    add(0,0,8'h00,1, 1,1,8'h14,2);
    add(0,0,8'h00,1, 1,1,8'h15,1);
    add(0,0,8'h00,0, 1,0,8'h00,0);
    // test 2: 3 in / 3 out, then wrap
    add(0,1,8'h21,0, 1,0,8'h00,0);
    add(0,1,8'h22,0, 1,1,8'h21,1);
    add(0,1,8'h23,0, 1,1,8'h21,2);
    add(0,0,8'h00,1, 1,1,8'h21,3);
    add(0,0,8'h00,1, 1,1,8'h22,2);
    add(0,0,8'h00,1, 1,1,8'h23,1);
    add(0,1,8'hA0,0, 1,0,8'h00,0);
    add(0,1,8'hA1,0, 1,1,8'hA0,1);
    add(0,1,8'hA2,0, 1,1,8'hA0,2);
    add(0,1,8'hA3,0, 1,1,8'hA0,3);
    add(0,1,8'hA4,0, 1,1,8'hA0,4);
    add(0,0,8'h00,1, 0,1,8'hA0,5);
    add(0,0,8'h00,1, 1,1,8'hA1,4);
    add(0,0,8'h00,1, 1,1,8'hA2,3);
    add(0,0,8'h00,1, 1,1,8'hA3,2);
    add(0,0,8'h00,1, 1,1,8'hA4,1);
    add(0,0,8'h00,0, 1,0,8'h00,0);
    // test 5: clear beats a same-cycle push
    add(0,1,8'h31,0, 1,0,8'h00,0);
    add(0,1,8'h32,0, 1,1,8'h31,1);
    add(0,1,8'h33,0, 1,1,8'h31,2);
    add(1,1,8'h34,1, 1,1,8'h31,3);
    add(0,0,8'h00,0, 1,0,8'h00,0);
    add(0,1,8'h35,0, 1,0,8'h00,0);
    add(0,0,8'h00,1, 1,1,8'h35,1);
    add(0,0,8'h00,0, 1,0,8'h00,0);

    #12;
    chk("rst_a_ir",  32'(a_cdi_rdy), 1);
    chk("rst_a_ov",  32'(a_cdo_vld), 0);
    chk("rst_a_lvl", 32'(a_lvl), 0);
    chk("rst_a_afl", 32'(a_afl), 0);
    chk("rst_a_aem", 32'(a_aem), 1);
    chk("rst_b_ir",  32'(b_cdi_rdy), 1);
    chk("rst_b_ov",  32'(b_cdo_vld), 0);
    chk("rst_b_lvl", 32'(b_lvl), 0);
    #10 rst = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk); #1;
      a_clr = tv[i].clr; a_vld = tv[i].vld;
      a_dat = tv[i].dat; a_rdy = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_ir", i),
          32'(a_cdi_rdy), 32'(tv[i].e_ir));
      chk($sformatf("v%0d_ov", i),
          32'(a_cdo_vld), 32'(tv[i].e_ov));
      if (tv[i].e_ov)
        chk($sformatf("v%0d_dat", i),
            32'(a_cdo_dat), 32'(tv[i].e_dat));
      chk($sformatf("v%0d_lvl", i),
          32'(a_lvl), 32'(tv[i].e_lvl));
      chk($sformatf("v%0d_afl", i),
          32'(a_afl), 32'(tv[i].e_lvl >= 3'd4));
      chk($sformatf("v%0d_aem", i),
          32'(a_aem), 32'(tv[i].e_lvl <= 3'd1));
    end

    // test 3: full, push and pop held together
    for (int i = 0; i < 5; i++)
      cyc_a(1'b1, 8'(8'h40 + i), 1'b0, "t3f");
    nxt = 8'h45;
    for (int i = 0; i < 10; i++) begin
      cyc_a(1'b1, nxt, 1'b1, "t3");
      chk("t3_in",  32'(a_cdi_rdy), 32'(i != 0));
      chk("t3_out", 32'(a_cdo_vld), 1);
      if (a_cdi_rdy) nxt = nxt + 8'd1;
    end
    for (int i = 0; i < 6; i++)
      cyc_a(1'b0, 8'h00, 1'b1, "t3d");
    cyc_a(1'b0, 8'h00, 1'b0, "t3e");

    // test 4: registered output, 2-cycle latency
    cyc_b(1'b1, 8'h5A, 1'b0);
    chk("t4_ov0", 32'(b_cdo_vld), 0);
    cyc_b(1'b0, 8'h00, 1'b0);
    chk("t4_ov1", 32'(b_cdo_vld), 0);
    chk("t4_lv1", 32'(b_lvl), 1);
    cyc_b(1'b1, 8'h61, 1'b0);
    chk("t4_ov2", 32'(b_cdo_vld), 1);
    chk("t4_dt2", 32'(b_cdo_dat), 32'h5A);
    chk("t4_lv2", 32'(b_lvl), 1);
    cyc_b(1'b1, 8'h62, 1'b0);
    chk("t4_lv3", 32'(b_lvl), 2);
    cyc_b(1'b1, 8'h63, 1'b0);
    chk("t4_lv4", 32'(b_lvl), 3);
    chk("t4_af4", 32'(b_afl), 1);
    cyc_b(1'b1, 8'h64, 1'b0);
    chk("t4_lv5", 32'(b_lvl), 4);
    chk("t4_ir5", 32'(b_cdi_rdy), 1);
    cyc_b(1'b1, 8'h65, 1'b0);
    chk("t4_lv6", 32'(b_lvl), 5);
    chk("t4_ir6", 32'(b_cdi_rdy), 0);
    chk("t4_af6", 32'(b_afl), 1);
    for (int i = 0; i < 5; i++) begin
      cyc_b(1'b0, 8'h00, 1'b1);
      chk($sformatf("t4_pv%0d", i),
          32'(b_cdo_vld), 1);
      chk($sformatf("t4_pd%0d", i),
          32'(b_cdo_dat), 32'(bexp[i]));
      chk($sformatf("t4_pl%0d", i),
          32'(b_lvl), 32'(5 - i));
    end
    cyc_b(1'b0, 8'h00, 1'b0);
    chk("t4_ove", 32'(b_cdo_vld), 0);
    chk("t4_lve", 32'(b_lvl), 0);
    chk("t4_aee", 32'(b_aem), 1);

    // test 6: async reset mid-burst
    for (int i = 0; i < 4; i++)
      cyc_a(1'b1, 8'(8'h50 + i), 1'b0, "t6f");
    @(posedge clk); #1;
    chk("t6_pre_lvl", 32'(a_lvl), 4);
    a_vld = 1'b1; a_dat = 8'h54; a_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_ov",  32'(a_cdo_vld), 0);
    chk("t6_ir",  32'(a_cdi_rdy), 1);
    chk("t6_lvl", 32'(a_lvl), 0);
    chk("t6_aem", 32'(a_aem), 1);
    chk("t6_afl", 32'(a_afl), 0);
    @(negedge clk); #1;
    rst = 1'b1;
    a_vld = 1'b0;
    mq.delete();
    cyc_a(1'b1, 8'h77, 1'b0, "t6p");
    cyc_a(1'b0, 8'h00, 1'b1, "t6r");
    cyc_a(1'b0, 8'h00, 1'b0, "t6e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
